// File: rtl/mem_stage_lsu_if.sv
// EX-result, data-memory and MEM/WB signal bundle for the rv32i MEM stage.
// master = surrounding pipeline/memory, slave = the MEM stage itself.
interface mem_stage_lsu_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_load_regfile;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_rs2_data;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_load_regfile;
  logic        wb_misalign;
  logic        wb_bus_err;

  modport master (
    output ex_valid, ex_opcode, ex_funct3, ex_rd, ex_load_regfile, ex_alu_out, ex_rs2_data,
    output dmem_resp, dmem_rdata,
    input  ex_ready, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_wmask,
    input  wb_valid, wb_rd, wb_data, wb_load_regfile, wb_misalign, wb_bus_err
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_funct3, ex_rd, ex_load_regfile, ex_alu_out, ex_rs2_data,
    input  dmem_resp, dmem_rdata,
    output ex_ready, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_wmask,
    output wb_valid, wb_rd, wb_data, wb_load_regfile, wb_misalign, wb_bus_err
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// rv32i MEM stage: load/store handshake with data memory, byte-lane steering,
// load extension, misalignment trap, access timeout and MEM/WB register.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_stage_lsu_if.slave  bus
);
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic        rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [15:0] cnt_q, cnt_d;
  // instruction held while the access is outstanding
  logic [2:0]  op_f3_q, op_f3_d;
  logic [1:0]  op_off_q, op_off_d;
  logic [4:0]  op_rd_q, op_rd_d;
  logic        op_lrf_q, op_lrf_d;
  logic [31:0] op_alu_q, op_alu_d;
  logic        wb_valid_q, wb_valid_d, wb_lrf_q, wb_lrf_d;
  logic        wb_mis_q, wb_mis_d, wb_err_q, wb_err_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic       is_load, is_store, misalign;
  logic [1:0] off;

  assign is_load  = (bus.ex_opcode == OP_LOAD);
  assign is_store = (bus.ex_opcode == OP_STORE);
  assign off      = bus.ex_alu_out[1:0];
  // funct3[1:0]: 00 byte, 01 half, else word (covers the undefined encodings)
  assign misalign = (bus.ex_funct3[1:0] == 2'b01) ? off[0] :
                    (bus.ex_funct3[1:0] == 2'b00) ? 1'b0 : (off != 2'b00);

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{o, 3'b000} +: 8];
    h = rdata[{o[1], 4'b0000} +: 16];
    case (f3[1:0])
      2'b00:   load_ext = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_ext = rdata;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    rd_req_d   = rd_req_q;
    wr_req_d   = wr_req_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    cnt_d      = cnt_q;
    op_f3_d    = op_f3_q;
    op_off_d   = op_off_q;
    op_rd_d    = op_rd_q;
    op_lrf_d   = op_lrf_q;
    op_alu_d   = op_alu_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_lrf_d   = wb_lrf_q;
    wb_mis_d   = wb_mis_q;
    wb_err_d   = wb_err_q;
    case (state_q)
      IDLE: if (bus.ex_valid) begin
        if ((is_load || is_store) && !misalign) begin
          state_d  = ACCESS;
          rd_req_d = is_load;
          wr_req_d = is_store;
          addr_d   = {bus.ex_alu_out[31:2], 2'b00};
          cnt_d    = '0;
          op_f3_d  = bus.ex_funct3;
          op_off_d = off;
          op_rd_d  = bus.ex_rd;
          op_lrf_d = bus.ex_load_regfile;
          op_alu_d = bus.ex_alu_out;
          wmask_d  = 4'b0000;
          wdata_d  = '0;
          if (is_store) begin
            case (bus.ex_funct3[1:0])
              2'b00: begin
                wmask_d = 4'b0001 << off;
                wdata_d = {4{bus.ex_rs2_data[7:0]}};
              end
              2'b01: begin
                wmask_d = 4'b0011 << {off[1], 1'b0};
                wdata_d = {2{bus.ex_rs2_data[15:0]}};
              end
              default: begin
                wmask_d = 4'b1111;
                wdata_d = bus.ex_rs2_data;
              end
            endcase
          end
        end else begin
          // pass-through ALU result, or a trapped misaligned access
          wb_valid_d = 1'b1;
          wb_rd_d    = bus.ex_rd;
          wb_data_d  = bus.ex_alu_out;
          wb_mis_d   = is_load || is_store;
          wb_err_d   = 1'b0;
          wb_lrf_d   = !(is_load || is_store) && bus.ex_load_regfile && (bus.ex_rd != 5'd0);
        end
      end
      ACCESS: begin
        if (bus.dmem_resp || (TO_EN && cnt_q == TO_LAST)) begin
          state_d    = IDLE;
          rd_req_d   = 1'b0;
          wr_req_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = op_rd_q;
          wb_mis_d   = 1'b0;
          wb_err_d   = !bus.dmem_resp;
          wb_data_d  = (bus.dmem_resp && rd_req_q) ? load_ext(op_f3_q, op_off_q, bus.dmem_rdata)
                                                   : op_alu_q;
          wb_lrf_d   = bus.dmem_resp && rd_req_q && op_lrf_q && (op_rd_q != 5'd0);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cnt_q      <= '0;
      op_f3_q    <= '0;
      op_off_q   <= '0;
      op_rd_q    <= '0;
      op_lrf_q   <= 1'b0;
      op_alu_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_lrf_q   <= 1'b0;
      wb_mis_q   <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_req_q   <= rd_req_d;
      wr_req_q   <= wr_req_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      cnt_q      <= cnt_d;
      op_f3_q    <= op_f3_d;
      op_off_q   <= op_off_d;
      op_rd_q    <= op_rd_d;
      op_lrf_q   <= op_lrf_d;
      op_alu_q   <= op_alu_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_lrf_q   <= wb_lrf_d;
      wb_mis_q   <= wb_mis_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign bus.ex_ready        = (state_q == IDLE);
  assign bus.dmem_read       = rd_req_q;
  assign bus.dmem_write      = wr_req_q;
  assign bus.dmem_address    = addr_q;
  assign bus.dmem_wdata      = wdata_q;
  assign bus.dmem_wmask      = wmask_q;
  assign bus.wb_valid        = wb_valid_q;
  assign bus.wb_rd           = wb_rd_q;
  assign bus.wb_data         = wb_data_q;
  assign bus.wb_load_regfile = wb_lrf_q;
  assign bus.wb_misalign     = wb_mis_q;
  assign bus.wb_bus_err      = wb_err_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: default instance plus a TIMEOUT_CYCLES=4 instance.
module tb_mem_stage_lsu;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic clk, rst_n;
  int   checks, failures;

  mem_stage_lsu_if bus();
  mem_stage_lsu_if bus4();

  mem_stage_lsu u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic lrf, input logic [31:0] alu, input logic [31:0] rs2);
    bus.ex_valid = 1'b1; bus.ex_opcode = op; bus.ex_funct3 = f3; bus.ex_rd = rd;
    bus.ex_load_regfile = lrf; bus.ex_alu_out = alu; bus.ex_rs2_data = rs2;
  endtask

  task automatic issue4(input logic [31:0] alu);
    bus4.ex_valid = 1'b1; bus4.ex_opcode = OP_LOAD; bus4.ex_funct3 = 3'b010; bus4.ex_rd = 5'd9;
    bus4.ex_load_regfile = 1'b1; bus4.ex_alu_out = alu; bus4.ex_rs2_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if (bus.ex_ready !== 1'b1) begin failures++; $display("FAIL rst_ex_ready got %b exp 1", bus.ex_ready); end
    checks++; if ({bus.dmem_read, bus.dmem_write} !== 2'b00) begin failures++; $display("FAIL rst_req got %b exp 00", {bus.dmem_read, bus.dmem_write}); end
    checks++; if (bus.dmem_address !== 32'd0 || bus.dmem_wdata !== 32'd0 || bus.dmem_wmask !== 4'd0) begin failures++; $display("FAIL rst_dmem got %h %h %b exp zeros", bus.dmem_address, bus.dmem_wdata, bus.dmem_wmask); end
    checks++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_load_regfile, bus.wb_misalign, bus.wb_bus_err} !== 41'd0) begin failures++; $display("FAIL rst_wb got v=%b data=%h exp zeros", bus.wb_valid, bus.wb_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_back_to_back();
    issue(OP_ALU, 3'b000, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'h0);
    step();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hDEAD_BEEF || bus.wb_rd !== 5'd5 || bus.wb_load_regfile !== 1'b1) begin failures++; $display("FAIL alu1 got v=%b d=%h rd=%0d lrf=%b exp 1 deadbeef 5 1", bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_load_regfile); end
    issue(OP_ALU, 3'b000, 5'd0, 1'b1, 32'h0000_1234, 32'h0);
    step();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0000_1234 || bus.wb_load_regfile !== 1'b0) begin failures++; $display("FAIL alu_rd0 got v=%b d=%h lrf=%b exp 1 00001234 0", bus.wb_valid, bus.wb_data, bus.wb_load_regfile); end
    bus.ex_valid = 1'b0;
    step();
    checks++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== 32'h0000_1234) begin failures++; $display("FAIL alu_hold got v=%b d=%h exp 0 00001234", bus.wb_valid, bus.wb_data); end
  endtask

  task automatic test_loads();
    issue(OP_LOAD, 3'b000, 5'd7, 1'b1, 32'h0000_0103, 32'h0);
    step();
    bus.ex_valid = 1'b0;
    checks++; if (bus.dmem_read !== 1'b1 || bus.dmem_address !== 32'h100 || bus.dmem_wmask !== 4'b0000 || bus.ex_ready !== 1'b0 || bus.wb_valid !== 1'b0) begin failures++; $display("FAIL lb_req got rd=%b a=%h m=%b rdy=%b v=%b", bus.dmem_read, bus.dmem_address, bus.dmem_wmask, bus.ex_ready, bus.wb_valid); end
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h80AA_BBCC;
    step();
    bus.dmem_resp = 1'b0;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hFFFF_FF80 || bus.wb_load_regfile !== 1'b1 || bus.wb_rd !== 5'd7) begin failures++; $display("FAIL lb_wb got v=%b d=%h lrf=%b exp 1 ffffff80 1", bus.wb_valid, bus.wb_data, bus.wb_load_regfile); end
    checks++; if (bus.dmem_read !== 1'b0 || bus.ex_ready !== 1'b1) begin failures++; $display("FAIL lb_release got rd=%b rdy=%b exp 0 1", bus.dmem_read, bus.ex_ready); end
    step();
    checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL lb_pulse got v=%b exp 0", bus.wb_valid); end

    issue(OP_LOAD, 3'b101, 5'd8, 1'b1, 32'h0000_0102, 32'h0);
    step();
    bus.ex_valid = 1'b0;
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h8001_0000;
    step();
    bus.dmem_resp = 1'b0;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0000_8001) begin failures++; $display("FAIL lhu got v=%b d=%h exp 1 00008001", bus.wb_valid, bus.wb_data); end

    issue(OP_LOAD, 3'b001, 5'd8, 1'b1, 32'h0000_0102, 32'h0);
    step();
    bus.ex_valid = 1'b0;
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h8001_0000;
    step();
    bus.dmem_resp = 1'b0;
    checks++; if (bus.wb_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh got d=%h exp ffff8001", bus.wb_data); end

    issue(OP_LOAD, 3'b010, 5'd6, 1'b1, 32'h0000_0102, 32'h0);
    step();
    bus.ex_valid = 1'b0;
    checks++; if (bus.dmem_read !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wb_misalign !== 1'b1 || bus.wb_load_regfile !== 1'b0 || bus.ex_ready !== 1'b1) begin failures++; $display("FAIL lw_misalign got rd=%b v=%b mis=%b lrf=%b rdy=%b", bus.dmem_read, bus.wb_valid, bus.wb_misalign, bus.wb_load_regfile, bus.ex_ready); end
    step();

    issue(OP_LOAD, 3'b010, 5'd0, 1'b1, 32'h0000_0400, 32'h0);
    step();
    bus.ex_valid = 1'b0;
    checks++; if (bus.dmem_read !== 1'b1) begin failures++; $display("FAIL lw_rd0_req got %b exp 1", bus.dmem_read); end
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
    step();
    bus.dmem_resp = 1'b0;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hCAFE_F00D || bus.wb_load_regfile !== 1'b0 || bus.wb_misalign !== 1'b0) begin failures++; $display("FAIL lw_rd0 got v=%b d=%h lrf=%b mis=%b", bus.wb_valid, bus.wb_data, bus.wb_load_regfile, bus.wb_misalign); end
  endtask

  task automatic test_stores();
    logic [2:0]  f3s  [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] adrs [3] = '{32'h201, 32'h202, 32'h204};
    logic [3:0]  msks [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] dats [3] = '{32'h7878_7878, 32'h5678_5678, 32'h1234_5678};
    logic [31:0] wadr [3] = '{32'h200, 32'h200, 32'h204};
    for (int i = 0; i < 3; i++) begin
      issue(OP_STORE, f3s[i], 5'd3, 1'b0, adrs[i], 32'h1234_5678);
      step();
      bus.ex_valid = 1'b0;
      checks++; if (bus.dmem_write !== 1'b1 || bus.dmem_read !== 1'b0 || bus.dmem_address !== wadr[i] || bus.dmem_wmask !== msks[i] || bus.dmem_wdata !== dats[i]) begin failures++; $display("FAIL store%0d got w=%b a=%h m=%b d=%h exp %h %b %h", i, bus.dmem_write, bus.dmem_address, bus.dmem_wmask, bus.dmem_wdata, wadr[i], msks[i], dats[i]); end
      bus.dmem_resp = 1'b1;
      step();
      bus.dmem_resp = 1'b0;
      checks++; if (bus.wb_valid !== 1'b1 || bus.wb_load_regfile !== 1'b0 || bus.dmem_write !== 1'b0) begin failures++; $display("FAIL store%0d_wb got v=%b lrf=%b w=%b exp 1 0 0", i, bus.wb_valid, bus.wb_load_regfile, bus.dmem_write); end
    end
  endtask

  task automatic test_delayed_resp();
    int low_cnt, pulses;
    low_cnt = 0; pulses = 0;
    issue(OP_LOAD, 3'b010, 5'd3, 1'b1, 32'h0000_0300, 32'h0);
    step();
    bus.ex_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!bus.ex_ready) low_cnt++;
      checks++; if (bus.dmem_read !== 1'b1 || bus.dmem_address !== 32'h300 || bus.wb_valid !== 1'b0) begin failures++; $display("FAIL delay_stable%0d got rd=%b a=%h v=%b", i, bus.dmem_read, bus.dmem_address, bus.wb_valid); end
      if (i == 5) begin bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h1111_2222; end
      step();
      bus.dmem_resp = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.wb_valid) pulses++;
      if (i == 0) begin
        checks++; if (bus.wb_data !== 32'h1111_2222 || bus.ex_ready !== 1'b1) begin failures++; $display("FAIL delay_wb got d=%h rdy=%b exp 11112222 1", bus.wb_data, bus.ex_ready); end
      end
      step();
    end
    checks++; if (low_cnt !== 6) begin failures++; $display("FAIL delay_ready_low got %0d exp 6", low_cnt); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL delay_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_timeout();
    issue4(32'h0000_0010);
    step();
    bus4.ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus4.dmem_read !== 1'b1 || bus4.wb_valid !== 1'b0) begin failures++; $display("FAIL to_wait%0d got rd=%b v=%b exp 1 0", i, bus4.dmem_read, bus4.wb_valid); end
      step();
    end
    checks++; if (bus4.wb_valid !== 1'b1 || bus4.wb_bus_err !== 1'b1 || bus4.wb_load_regfile !== 1'b0 || bus4.dmem_read !== 1'b0 || bus4.ex_ready !== 1'b1) begin failures++; $display("FAIL to_abort got v=%b err=%b lrf=%b rd=%b rdy=%b", bus4.wb_valid, bus4.wb_bus_err, bus4.wb_load_regfile, bus4.dmem_read, bus4.ex_ready); end
    step();
    issue4(32'h0000_0020);
    step();
    bus4.ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    bus4.dmem_resp = 1'b1; bus4.dmem_rdata = 32'h0BAD_F00D;
    step();
    bus4.dmem_resp = 1'b0;
    checks++; if (bus4.wb_valid !== 1'b1 || bus4.wb_bus_err !== 1'b0 || bus4.wb_data !== 32'h0BAD_F00D || bus4.wb_load_regfile !== 1'b1) begin failures++; $display("FAIL to_resp_wins got v=%b err=%b d=%h lrf=%b", bus4.wb_valid, bus4.wb_bus_err, bus4.wb_data, bus4.wb_load_regfile); end
    step();
  endtask

  task automatic test_reset_mid_access();
    issue(OP_LOAD, 3'b010, 5'd4, 1'b1, 32'h0000_0500, 32'h0);
    step();
    bus.ex_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (bus.dmem_read !== 1'b0 || bus.ex_ready !== 1'b1 || bus.dmem_address !== 32'd0 || bus.wb_valid !== 1'b0 || bus.wb_data !== 32'd0) begin failures++; $display("FAIL midrst got rd=%b rdy=%b a=%h v=%b d=%h", bus.dmem_read, bus.ex_ready, bus.dmem_address, bus.wb_valid, bus.wb_data); end
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    step();
    bus.dmem_resp = 1'b0;
    checks++; if (bus.wb_valid !== 1'b0 || bus.ex_ready !== 1'b1 || bus.dmem_read !== 1'b0) begin failures++; $display("FAIL stray_resp got v=%b rdy=%b rd=%b exp 0 1 0", bus.wb_valid, bus.ex_ready, bus.dmem_read); end
    issue(OP_ALU, 3'b000, 5'd2, 1'b1, 32'h0000_00AB, 32'h0);
    step();
    bus.ex_valid = 1'b0;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0000_00AB || bus.wb_rd !== 5'd2) begin failures++; $display("FAIL post_rst_alu got v=%b d=%h rd=%0d exp 1 000000ab 2", bus.wb_valid, bus.wb_data, bus.wb_rd); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_opcode = '0; bus.ex_funct3 = '0; bus.ex_rd = '0;
    bus.ex_load_regfile = 1'b0; bus.ex_alu_out = '0; bus.ex_rs2_data = '0;
    bus.dmem_resp = 1'b0; bus.dmem_rdata = '0;
    bus4.ex_valid = 1'b0; bus4.ex_opcode = '0; bus4.ex_funct3 = '0; bus4.ex_rd = '0;
    bus4.ex_load_regfile = 1'b0; bus4.ex_alu_out = '0; bus4.ex_rs2_data = '0;
    bus4.dmem_resp = 1'b0; bus4.dmem_rdata = '0;
    test_reset();
    test_alu_back_to_back();
    test_loads();
    test_stores();
    test_delayed_resp();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
